// File: rtl/pipeline_ctrl_if.sv
// Stage-field and control bundle between the 5-stage datapath and
// pipeline_ctrl. The datapath (or a bench) drives it through the master
// modport and the controller consumes it through the slave modport.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID stage
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  // EXE stage
  logic             exe_wreg;
  logic             exe_m2reg;
  logic [4:0]       exe_rn;
  logic             exe_is_beq;
  logic             exe_is_bne;
  logic             exe_is_jump;
  logic             exe_zero;
  logic [31:0]      exe_bpc;
  // MEM stage
  logic             mem_wreg;
  logic [4:0]       mem_rn;
  logic             mem_access;
  logic             dmem_ready;
  // halt request
  logic             halt_req;
  // controls
  logic             pc_wen;
  logic             pc_sel_branch;
  logic [31:0]      pc_target;
  logic             if_id_wen;
  logic             if_id_flush;
  logic             id_exe_bubble;
  logic             pipe_freeze;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  exe_wreg, exe_m2reg, exe_rn, exe_is_beq, exe_is_bne, exe_is_jump,
    input  exe_zero, exe_bpc,
    input  mem_wreg, mem_rn, mem_access, dmem_ready, halt_req,
    output pc_wen, pc_sel_branch, pc_target, if_id_wen, if_id_flush,
    output id_exe_bubble, pipe_freeze, fwda, fwdb, halted,
    output stall_cnt, flush_cnt
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output exe_wreg, exe_m2reg, exe_rn, exe_is_beq, exe_is_bne, exe_is_jump,
    output exe_zero, exe_bpc,
    output mem_wreg, mem_rn, mem_access, dmem_ready, halt_req,
    input  pc_wen, pc_sel_branch, pc_target, if_id_wen, if_id_flush,
    input  id_exe_bubble, pipe_freeze, fwda, fwdb, halted,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing and hazard controller for the 5-stage CPU.
// Hazard, forwarding and redirect controls are combinational from the
// current stage fields plus the RUN/DRAIN/HALTED state. The ordering is
// data-memory freeze, then taken branch, then load-use; a higher-priority
// event suppresses the lower ones. Stall and flush counters saturate.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             clrn,
  pipeline_ctrl_if.slave   bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_r;
  logic [DW-1:0]    drain_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic freeze_s;
  logic taken_s;
  logic load_use_s;
  logic stall_inc_s;
  logic flush_inc_s;

  logic pc_wen_s;
  logic pc_sel_branch_s;
  logic if_id_wen_s;
  logic if_id_flush_s;
  logic id_exe_bubble_s;
  logic pipe_freeze_s;

  // Operand source: EXE ALU result beats MEM result; r0 never forwards.
  // A load in EXE has no result yet, so it is not a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == src)) begin
      sel = 2'b01;
    end else if (m_wreg && (m_rn != 5'd0) && (m_rn == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Saturating increment: all-ones sticks instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  assign freeze_s   = bus.mem_access & ~bus.dmem_ready;
  assign taken_s    = bus.exe_is_jump | (bus.exe_is_beq & bus.exe_zero) |
                      (bus.exe_is_bne & ~bus.exe_zero);
  assign load_use_s = bus.exe_wreg & bus.exe_m2reg & (bus.exe_rn != 5'd0) &
                      ((bus.id_use_rs & (bus.id_rs == bus.exe_rn)) |
                       (bus.id_use_rt & (bus.id_rt == bus.exe_rn)));

  // A frozen cycle counts as a stall; a load-use bubble only counts when
  // no taken branch overrides it.
  assign stall_inc_s = freeze_s | (load_use_s & ~taken_s);
  assign flush_inc_s = ~freeze_s & taken_s;

  // Stage enables and strobes from hazard priority and the current state.
  always_comb begin
    pc_wen_s        = 1'b0;
    pc_sel_branch_s = 1'b0;
    if_id_wen_s     = 1'b0;
    if_id_flush_s   = 1'b0;
    id_exe_bubble_s = 1'b0;
    pipe_freeze_s   = 1'b0;
    if (!clrn) begin
      pc_wen_s = 1'b0;
    end else if (freeze_s) begin
      pipe_freeze_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (taken_s) begin
            pc_wen_s        = 1'b1;
            pc_sel_branch_s = 1'b1;
            if_id_wen_s     = 1'b1;
            if_id_flush_s   = 1'b1;
            id_exe_bubble_s = 1'b1;
          end else if (load_use_s) begin
            id_exe_bubble_s = 1'b1;
          end else begin
            pc_wen_s    = 1'b1;
            if_id_wen_s = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (taken_s) begin
            pc_wen_s        = 1'b1;
            pc_sel_branch_s = 1'b1;
            if_id_wen_s     = 1'b1;
            if_id_flush_s   = 1'b1;
            id_exe_bubble_s = 1'b1;
          end else if (load_use_s) begin
            id_exe_bubble_s = 1'b1;
          end else begin
            if_id_wen_s   = 1'b1;
            if_id_flush_s = 1'b1;
          end
        end
        ST_HALTED: begin
          if_id_wen_s     = 1'b1;
          if_id_flush_s   = 1'b1;
          id_exe_bubble_s = taken_s | load_use_s;
        end
        default: begin
          pc_wen_s = 1'b0;
        end
      endcase
    end
  end

  // RUN/DRAIN/HALTED sequencing; a frozen cycle holds state and drain count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= {DW{1'b0}};
    end else if (freeze_s) begin
      state_r     <= state_r;
      drain_cnt_r <= drain_cnt_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.halt_req && !taken_s && !load_use_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DW'(DRAIN_CYCLES - 1);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (load_use_s) begin
            state_r <= ST_DRAIN;
          end else if (drain_cnt_r == {DW{1'b0}}) begin
            state_r <= ST_HALTED;
          end else begin
            drain_cnt_r <= drain_cnt_r - DW'(1);
          end
        end
        ST_HALTED: begin
          if (!bus.halt_req) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        default: begin
          state_r     <= ST_RUN;
          drain_cnt_r <= {DW{1'b0}};
        end
      endcase
    end
  end

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_inc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign bus.pc_wen        = pc_wen_s;
  assign bus.pc_sel_branch = pc_sel_branch_s;
  assign bus.pc_target     = bus.exe_bpc;
  assign bus.if_id_wen     = if_id_wen_s;
  assign bus.if_id_flush   = if_id_flush_s;
  assign bus.id_exe_bubble = id_exe_bubble_s;
  assign bus.pipe_freeze   = pipe_freeze_s;
  assign bus.fwda          = fwd_sel(bus.id_rs, bus.exe_wreg, bus.exe_m2reg,
                                     bus.exe_rn, bus.mem_wreg, bus.mem_rn);
  assign bus.fwdb          = fwd_sel(bus.id_rt, bus.exe_wreg, bus.exe_m2reg,
                                     bus.exe_rn, bus.mem_wreg, bus.mem_rn);
  assign bus.halted        = (state_r == ST_HALTED);
  assign bus.stall_cnt     = stall_cnt_r;
  assign bus.flush_cnt     = flush_cnt_r;

endmodule
